// File: rtl/board_renderer_if.sv
// Bundle between the game datapath, the board renderer and the VGA adapter.
//   mineMap/flagMap/stepMap/posMap : 64-bit game-state bitmaps, bit i = cell row*8+col
//   x/y/color/en                   : pixel write to the VGA adapter, one per clock
//   busy/frame_done                : frame status back to the datapath
// master = game-state source / pixel sink, slave = board_renderer.
interface board_renderer_if;
  logic [63:0] mineMap;
  logic [63:0] flagMap;
  logic [63:0] stepMap;
  logic [63:0] posMap;
  logic [7:0]  x;
  logic [6:0]  y;
  logic [2:0]  color;
  logic        en;
  logic        busy;
  logic        frame_done;

  modport master (
    output mineMap, flagMap, stepMap, posMap,
    input  x, y, color, en, busy, frame_done
  );

  modport slave (
    input  mineMap, flagMap, stepMap, posMap,
    output x, y, color, en, busy, frame_done
  );
endinterface

// File: rtl/board_renderer.sv
// Rasterises the 8x8 minefield into the 160x120 frame buffer, one pixel per clock.
// A frame is drawn from a snapshot of the maps; any difference between the live
// maps and the snapshot marks the board dirty and schedules the next frame.
// Ports:
//   clk    : system clock
//   resetn : asynchronous active-low reset
//   bus    : slave side of board_renderer_if (maps in, pixel/status out)
module board_renderer #(
  parameter int unsigned CELL_PX = 12,
  parameter int unsigned X0      = 32,
  parameter int unsigned Y0      = 12
) (
  input  logic            clk,
  input  logic            resetn,
  board_renderer_if.slave bus
);

  localparam int unsigned LW = $clog2(CELL_PX);
  localparam int unsigned XW = 8;
  localparam int unsigned YW = 7;
  localparam int unsigned CW = 3;
  localparam int unsigned MW = 64;
  localparam int unsigned NW = 4;

  localparam logic [LW-1:0] L_LAST = LW'(CELL_PX - 1);
  localparam logic [LW-1:0] L_PRE  = LW'(CELL_PX - 2);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SNAP = 2'd1,
    S_DRAW = 2'd2,
    S_DONE = 2'd3
  } state_e;

  state_e          state_q, state_d;
  logic            dirty_q, dirty_d;
  logic [MW-1:0]   mine_snap_q, mine_snap_d;
  logic [MW-1:0]   flag_snap_q, flag_snap_d;
  logic [MW-1:0]   step_snap_q, step_snap_d;
  logic [MW-1:0]   pos_snap_q,  pos_snap_d;
  logic [LW-1:0]   lx_q, lx_d, ly_q, ly_d;
  logic [2:0]      col_q, col_d, row_q, row_d;
  logic [XW-1:0]   x_q, x_d;
  logic [YW-1:0]   y_q, y_d;
  logic [CW-1:0]   color_q, color_d;
  logic            en_q, en_d;
  logic            busy_q, busy_d;
  logic            frame_done_q, frame_done_d;

  logic [5:0]      cell_c;
  logic [NW-1:0]   adj_c;
  logic [CW-1:0]   color_c;
  logic            maps_differ_c;
  logic            last_pixel_c;

  // Mine lookup with clipping at the board edge (no wrap between rows).
  function automatic logic mine_at(input logic [MW-1:0] m, input int r, input int c);
    if (r < 0 || r > 7 || c < 0 || c > 7) return 1'b0;
    return m[6'(r * 8 + c)];
  endfunction

  assign cell_c        = {row_q, col_q};
  assign maps_differ_c = ({bus.mineMap, bus.flagMap, bus.stepMap, bus.posMap} !=
                          {mine_snap_q, flag_snap_q, step_snap_q, pos_snap_q});
  assign last_pixel_c  = (lx_q == L_LAST) && (col_q == 3'd7) &&
                         (ly_q == L_LAST) && (row_q == 3'd7);

  // Adjacent-mine count of the cell under the scan counters.
  always_comb begin
    adj_c = '0;
    for (int dr = -1; dr <= 1; dr++) begin
      for (int dc = -1; dc <= 1; dc++) begin
        if (!(dr == 0 && dc == 0)) begin
          adj_c = adj_c + NW'(mine_at(mine_snap_q, int'(row_q) + dr, int'(col_q) + dc));
        end
      end
    end
  end

  // Pixel colour, first matching rule wins.
  always_comb begin
    color_c = 3'b011;
    if (lx_q == L_LAST || ly_q == L_LAST) begin
      color_c = 3'b000;
    end else if (pos_snap_q[cell_c] &&
                 (lx_q == '0 || ly_q == '0 || lx_q == L_PRE || ly_q == L_PRE)) begin
      color_c = 3'b110;
    end else if (step_snap_q[cell_c] && mine_snap_q[cell_c]) begin
      color_c = 3'b100;
    end else if (step_snap_q[cell_c]) begin
      case (adj_c)
        NW'(0):  color_c = 3'b111;
        NW'(1):  color_c = 3'b001;
        NW'(2):  color_c = 3'b010;
        default: color_c = 3'b110;
      endcase
    end else if (flag_snap_q[cell_c]) begin
      color_c = 3'b101;
    end
  end

  // Next-state, counters, snapshot and registered-output inputs.
  always_comb begin
    state_d      = state_q;
    dirty_d      = dirty_q | maps_differ_c;
    mine_snap_d  = mine_snap_q;
    flag_snap_d  = flag_snap_q;
    step_snap_d  = step_snap_q;
    pos_snap_d   = pos_snap_q;
    lx_d         = lx_q;
    ly_d         = ly_q;
    col_d        = col_q;
    row_d        = row_q;
    x_d          = '0;
    y_d          = '0;
    color_d      = '0;
    en_d         = 1'b0;
    busy_d       = 1'b0;
    frame_done_d = (state_q == S_DONE);

    case (state_q)
      S_IDLE: begin
        if (dirty_q) state_d = S_SNAP;
      end
      S_SNAP: begin
        mine_snap_d = bus.mineMap;
        flag_snap_d = bus.flagMap;
        step_snap_d = bus.stepMap;
        pos_snap_d  = bus.posMap;
        dirty_d     = 1'b0;
        lx_d        = '0;
        ly_d        = '0;
        col_d       = '0;
        row_d       = '0;
        state_d     = S_DRAW;
      end
      S_DRAW: begin
        en_d    = 1'b1;
        x_d     = XW'(X0) + XW'(col_q) * XW'(CELL_PX) + XW'(lx_q);
        y_d     = YW'(Y0) + YW'(row_q) * YW'(CELL_PX) + YW'(ly_q);
        color_d = color_c;
        // Nested wrap counters: lx, then col, then ly, then row.
        if (lx_q == L_LAST) begin
          lx_d = '0;
          if (col_q == 3'd7) begin
            col_d = '0;
            if (ly_q == L_LAST) begin
              ly_d  = '0;
              row_d = row_q + 3'd1;
            end else begin
              ly_d = ly_q + LW'(1);
            end
          end else begin
            col_d = col_q + 3'd1;
          end
        end else begin
          lx_d = lx_q + LW'(1);
        end
        if (last_pixel_c) state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d == S_SNAP) || (state_d == S_DRAW);
  end

  // State and output registers; reset leaves the board dirty to force a redraw.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= S_IDLE;
      dirty_q      <= 1'b1;
      mine_snap_q  <= '0;
      flag_snap_q  <= '0;
      step_snap_q  <= '0;
      pos_snap_q   <= '0;
      lx_q         <= '0;
      ly_q         <= '0;
      col_q        <= '0;
      row_q        <= '0;
      x_q          <= '0;
      y_q          <= '0;
      color_q      <= '0;
      en_q         <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      dirty_q      <= dirty_d;
      mine_snap_q  <= mine_snap_d;
      flag_snap_q  <= flag_snap_d;
      step_snap_q  <= step_snap_d;
      pos_snap_q   <= pos_snap_d;
      lx_q         <= lx_d;
      ly_q         <= ly_d;
      col_q        <= col_d;
      row_q        <= row_d;
      x_q          <= x_d;
      y_q          <= y_d;
      color_q      <= color_d;
      en_q         <= en_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign bus.x          = x_q;
  assign bus.y          = y_q;
  assign bus.color      = color_q;
  assign bus.en         = en_q;
  assign bus.busy       = busy_q;
  assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_board_renderer.sv
// Bench for board_renderer: expected frames are produced from the game rules by a
// reference model and queued; a monitor pops one entry per plotted pixel and
// scores each frame when frame_done pulses. Directed spot pixels are also checked.
module tb_board_renderer;

  localparam int CELL_PX   = 12;
  localparam int X0        = 32;
  localparam int Y0        = 12;
  localparam int BOARD_PX  = 8 * CELL_PX;
  localparam int FRAME_PIX = BOARD_PX * BOARD_PX;

  typedef struct packed {
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] c;
  } pix_t;

  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  board_renderer_if bus_if ();

  board_renderer #(.CELL_PX(CELL_PX), .X0(X0), .Y0(Y0)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus_if)
  );

  pix_t  exp_q[$];
  pix_t  got, want;
  int    total = 0;
  int    bad = 0;
  int    pix_cnt = 0;
  int    mism = 0;
  int    frame_no = 0;
  string first_bad = "";
  int    cap[160][120];
  int    first_x, first_y, last_x, last_y;

  task automatic check(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", name, act, req);
    end
  endtask

  task automatic check_px(input string name, input int px, input int py, input int req);
    check(name, cap[px][py], req);
  endtask

  // Reference colour of screen-relative board pixel (sx, sy) from the game rules.
  function automatic logic [2:0] ref_color(input logic [63:0] m, input logic [63:0] f,
                                           input logic [63:0] s, input logic [63:0] p,
                                           input int sx, input int sy);
    int c, r, lx, ly, i, n;
    c  = sx / CELL_PX;
    r  = sy / CELL_PX;
    lx = sx % CELL_PX;
    ly = sy % CELL_PX;
    i  = r * 8 + c;
    n  = 0;
    for (int j = 0; j < 64; j++) begin
      int rj, cj;
      rj = j / 8;
      cj = j % 8;
      if (j != i && (rj - r) * (rj - r) <= 1 && (cj - c) * (cj - c) <= 1 && m[j]) n++;
    end
    if (lx == CELL_PX - 1 || ly == CELL_PX - 1) return 3'b000;
    if (p[i] && (lx == 0 || ly == 0 || lx == CELL_PX - 2 || ly == CELL_PX - 2)) return 3'b110;
    if (s[i] && m[i]) return 3'b100;
    if (s[i]) begin
      if (n == 0) return 3'b111;
      if (n == 1) return 3'b001;
      if (n == 2) return 3'b010;
      return 3'b110;
    end
    if (f[i]) return 3'b101;
    return 3'b011;
  endfunction

  task automatic push_frame(input logic [63:0] m, input logic [63:0] f,
                            input logic [63:0] s, input logic [63:0] p);
    pix_t e;
    for (int sy = 0; sy < BOARD_PX; sy++) begin
      for (int sx = 0; sx < BOARD_PX; sx++) begin
        e.x = 8'(X0 + sx);
        e.y = 7'(Y0 + sy);
        e.c = ref_color(m, f, s, p, sx, sy);
        exp_q.push_back(e);
      end
    end
  endtask

  task automatic set_maps(input logic [63:0] m, input logic [63:0] f,
                          input logic [63:0] s, input logic [63:0] p);
    bus_if.mineMap = m;
    bus_if.flagMap = f;
    bus_if.stepMap = s;
    bus_if.posMap  = p;
  endtask

  task automatic wait_frame(input string name);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (bus_if.frame_done !== 1'b1 && n < 2 * FRAME_PIX);
    check({name, "_frame_done_seen"}, int'(bus_if.frame_done === 1'b1), 1);
  endtask

  task automatic wait_pix(input string name, input int target);
    int n;
    n = 0;
    while (pix_cnt < target && n < 2 * FRAME_PIX) begin
      @(negedge clk);
      n++;
    end
    check({name, "_pixel_reached"}, int'(pix_cnt >= target), 1);
  endtask

  // Monitor: score every plotted pixel against the queue, close frames on frame_done.
  initial begin
    forever begin
      @(negedge clk);
      if (bus_if.en === 1'b1) begin
        if (pix_cnt == 0) begin
          for (int i = 0; i < 160; i++)
            for (int j = 0; j < 120; j++) cap[i][j] = -1;
          first_x = int'(bus_if.x);
          first_y = int'(bus_if.y);
        end
        last_x = int'(bus_if.x);
        last_y = int'(bus_if.y);
        got.x = bus_if.x;
        got.y = bus_if.y;
        got.c = bus_if.color;
        if (exp_q.size() == 0) begin
          if (mism == 0) first_bad = $sformatf("unexpected pixel x=%0d y=%0d", got.x, got.y);
          mism++;
        end else begin
          want = exp_q.pop_front();
          if (got !== want) begin
            if (mism == 0)
              first_bad = $sformatf("pixel %0d got (%0d,%0d)=%03b want (%0d,%0d)=%03b",
                                    pix_cnt, got.x, got.y, got.c, want.x, want.y, want.c);
            mism++;
          end
        end
        if (int'(bus_if.x) < 160 && int'(bus_if.y) < 120)
          cap[bus_if.x][bus_if.y] = int'(bus_if.color);
        pix_cnt++;
      end
      if (bus_if.frame_done === 1'b1) begin
        frame_no++;
        check($sformatf("frame%0d_pixel_count", frame_no), pix_cnt, FRAME_PIX);
        check($sformatf("frame%0d_bad_pixels", frame_no), mism, 0);
        if (mism != 0) $display("  frame %0d first difference: %s", frame_no, first_bad);
        pix_cnt   = 0;
        mism      = 0;
        first_bad = "";
      end
    end
  end

  initial begin
    #5ms;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] rm, rf, rs, rp;
    int en_hi;

    // 1: reset, then a blank-board frame.
    resetn = 1'b0;
    set_maps('0, '0, '0, '0);
    repeat (3) @(negedge clk);
    check("reset_en",         int'(bus_if.en),         0);
    check("reset_x",          int'(bus_if.x),          0);
    check("reset_y",          int'(bus_if.y),          0);
    check("reset_color",      int'(bus_if.color),      0);
    check("reset_busy",       int'(bus_if.busy),       0);
    check("reset_frame_done", int'(bus_if.frame_done), 0);
    push_frame('0, '0, '0, '0);
    resetn = 1'b1;
    wait_frame("t1");
    check("t1_first_x", first_x, 32);
    check("t1_first_y", first_y, 12);
    check("t1_last_x",  last_x,  127);
    check("t1_last_y",  last_y,  107);
    check_px("t1_px_32_12",   32,  12,  3'b011);
    check_px("t1_px_127_107", 127, 107, 3'b000);
    check_px("t1_px_43_12",   43,  12,  3'b000);
    check_px("t1_px_37_17",   37,  17,  3'b011);
    en_hi = 0;
    repeat (20) begin
      @(negedge clk);
      en_hi += int'(bus_if.en);
    end
    check("t1_idle_en_pulses", en_hi, 0);
    check("t1_frame_count", frame_no, 1);

    // 2: revealed cell with three neighbouring mines.
    rm = 64'(1) | (64'(1) << 2) | (64'(1) << 16);
    rs = 64'(1) << 9;
    push_frame(rm, '0, rs, '0);
    set_maps(rm, '0, rs, '0);
    wait_frame("t2");
    check_px("t2_px_49_29", 49, 29, 3'b110);
    check_px("t2_px_37_17", 37, 17, 3'b011);

    // 3: no wrap between row ends.
    rm = 64'(1) << 7;
    rs = (64'(1) << 8) | (64'(1) << 15);
    push_frame(rm, '0, rs, '0);
    set_maps(rm, '0, rs, '0);
    wait_frame("t3");
    check_px("t3_px_37_29",  37,  29, 3'b111);
    check_px("t3_px_121_29", 121, 29, 3'b001);

    // 4/5: cursor on cell 0, then flag 63 toggled mid-frame.
    rp = 64'(1);
    push_frame('0, '0, '0, rp);
    set_maps('0, '0, '0, rp);
    wait_pix("t4", 2000);
    push_frame('0, 64'(1) << 63, '0, rp);
    set_maps('0, 64'(1) << 63, '0, rp);
    wait_frame("t4a");
    check_px("t5_px_32_12",   32,  12,  3'b110);
    check_px("t5_px_42_17",   42,  17,  3'b110);
    check_px("t5_px_37_17",   37,  17,  3'b011);
    check_px("t5_px_43_17",   43,  17,  3'b000);
    check_px("t4a_px_121_101", 121, 101, 3'b011);
    @(negedge clk);
    check("t4_busy_after_one_idle", int'(bus_if.busy), 1);
    check("t4_en_after_one_idle",   int'(bus_if.en),   0);
    wait_frame("t4b");
    check_px("t4b_px_121_101", 121, 101, 3'b101);

    // 6: random board, reset mid-frame, full redraw after release.
    rm = {$urandom(), $urandom()};
    rf = {$urandom(), $urandom()};
    rs = {$urandom(), $urandom()};
    rp = (64'(1) << $urandom_range(63)) | (64'(1) << $urandom_range(63));
    push_frame(rm, rf, rs, rp);
    set_maps(rm, rf, rs, rp);
    wait_pix("t6", 5000);
    @(negedge clk);
    #2;
    resetn = 1'b0;
    #1;
    check("t6_async_en",    int'(bus_if.en),    0);
    check("t6_async_x",     int'(bus_if.x),     0);
    check("t6_async_y",     int'(bus_if.y),     0);
    check("t6_async_color", int'(bus_if.color), 0);
    check("t6_partial_bad_pixels", mism, 0);
    exp_q.delete();
    pix_cnt   = 0;
    mism      = 0;
    first_bad = "";
    push_frame(rm, rf, rs, rp);
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    wait_frame("t6");
    check("t6_first_x", first_x, 32);
    check("t6_first_y", first_y, 12);

    // 7: second random board, mostly revealed, no cursor.
    rm = {$urandom(), $urandom()} & {$urandom(), $urandom()};
    rf = {$urandom(), $urandom()};
    rs = {$urandom(), $urandom()} | {$urandom(), $urandom()};
    push_frame(rm, rf, rs, '0);
    set_maps(rm, rf, rs, '0);
    wait_frame("t7");

    repeat (2) @(negedge clk);
    check("leftover_expected_pixels", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
